dmem_port_arbiter: RTL and testbench

//  Shares the single-port data memory (dmem) between the processor and the game

---
 rtl/dmem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Purpose: shares the single-port dmem between the processor (priority) and the game peripheral.
// Latency: grant is combinational in the request cycle; G read data returns READ_LAT cycles after its grant.
// Backpressure: a deferred processor access raises p_stall; the peripheral holds g_req until g_gnt.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  // processor side
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_stall,
  output logic [DATA_W-1:0] p_rdata,
  // peripheral side
  input  logic              g_req,
  input  logic              g_we,
  input  logic [ADDR_W-1:0] g_addr,
  input  logic [DATA_W-1:0] g_wdata,
  output logic              g_gnt,
  output logic              g_rvalid,
  output logic [DATA_W-1:0] g_rdata,
  // dmem side
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  // Counter must hold MAX_WAIT-1; one spare bit keeps the width safe for MAX_WAIT=1.
  localparam int CNT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [0:0] {
    ST_PRIO  = 1'b0,
    ST_FORCE = 1'b1
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   wait_cnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [READ_LAT-1:0] tag_vld_q;
  logic [READ_LAT-1:0] tag_g_q;

  logic              p_grant;
  logic              g_grant;
  logic              any_grant;
  logic              g_lost;
  logic [CNT_W:0]    wait_inc;
  logic              hit_limit;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;
  logic              mux_we;
  logic              push_rd;

  // Grant decision: FORCE hands the port to G if it still wants it, otherwise P first, then G.
  // Everything is masked by reset so the dmem sees no access while reset is low.
  always_comb begin
    p_grant = 1'b0;
    g_grant = 1'b0;
    if (reset) begin
      if ((state_q == ST_FORCE) && g_req) begin
        g_grant = 1'b1;
      end else if (p_req) begin
        p_grant = 1'b1;
      end else if (g_req) begin
        g_grant = 1'b1;
      end
    end
  end

  assign any_grant = p_grant | g_grant;
  assign g_lost    = g_req & ~g_grant;
  assign wait_inc  = {1'b0, wait_cnt_q} + (CNT_W + 1)'(1);
  // The losing cycle that brings the counter to MAX_WAIT-1 is the last one G loses.
  assign hit_limit = (wait_inc >= {1'b0, CNT_MAX});

  // Starvation FSM: counts consecutive G losses in PRIO, forces one G grant, then returns.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_PRIO;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_PRIO: begin
          if (g_lost) begin
            if (hit_limit) begin
              wait_cnt_q <= CNT_MAX;
              state_q    <= ST_FORCE;
            end else begin
              wait_cnt_q <= wait_inc[CNT_W-1:0];
            end
          end else begin
            // Either G was served or it is not asking (possibly an abort).
            wait_cnt_q <= '0;
          end
        end
        ST_FORCE: begin
          state_q    <= ST_PRIO;
          wait_cnt_q <= '0;
        end
        default: begin
          state_q    <= ST_PRIO;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  // Request mux toward dmem, selected by the current owner.
  always_comb begin
    mux_addr  = addr_q;
    mux_wdata = data_q;
    mux_we    = 1'b0;
    if (p_grant) begin
      mux_addr  = p_addr;
      mux_wdata = p_wdata;
      mux_we    = p_we;
    end else if (g_grant) begin
      mux_addr  = g_addr;
      mux_wdata = g_wdata;
      mux_we    = g_we;
    end
  end

  // Remember the last driven address/data so the dmem bus is quiet on idle cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (any_grant) begin
      addr_q <= mux_addr;
      data_q <= mux_wdata;
    end
  end

  assign address_dmem = mux_addr;
  assign data         = mux_wdata;
  assign wren         = any_grant & mux_we;
  assign p_stall      = p_req & ~p_grant & reset;
  assign g_gnt        = g_grant;

  // Every granted read enters the tag pipe with its owner (1 = peripheral).
  assign push_rd = any_grant & ~mux_we;

  // Tag pipe aligned with the dmem read latency; reset drops any read still in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_vld_q <= '0;
      tag_g_q   <= '0;
    end else begin
      tag_vld_q[0] <= push_rd;
      tag_g_q[0]   <= g_grant;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_g_q[i]   <= tag_g_q[i-1];
      end
    end
  end

  assign g_rvalid = tag_vld_q[READ_LAT-1] & tag_g_q[READ_LAT-1];
  assign g_rdata  = g_rvalid ? q_dmem : '0;
  // The processor samples read data on its own schedule.
  assign p_rdata  = q_dmem;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a one-cycle synchronous dmem model.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Expected values are hand-derived constants.
module tb_dmem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        p_req, p_we;
  logic [11:0] p_addr;
  logic [31:0] p_wdata;
  logic        p_stall;
  logic [31:0] p_rdata;
  logic        g_req, g_we;
  logic [11:0] g_addr;
  logic [31:0] g_wdata;
  logic        g_gnt, g_rvalid;
  logic [31:0] g_rdata;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;

  logic [31:0] mem [0:4095];

  int checks = 0;
  int errors = 0;

  dmem_port_arbiter #(
    .ADDR_W(12), .DATA_W(32), .MAX_WAIT(8), .READ_LAT(1)
  ) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rdata(p_rdata),
    .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
    .g_gnt(g_gnt), .g_rvalid(g_rvalid), .g_rdata(g_rdata),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
  );

  always #5 clock = ~clock;

  // Single-port dmem, one-cycle read latency.
  always @(posedge clock) begin
    if (wren) mem[address_dmem] <= data;
    q_dmem <= mem[address_dmem];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h010] = 32'hCAFEF00D;
    mem[12'h001] = 32'hA0A00001;
    mem[12'h002] = 32'hB0B00002;
    mem[12'h200] = 32'h12345678;
    q_dmem = 32'h0;

    // Reset with both requesters active: nothing may reach the dmem.
    reset = 1'b0;
    p_req = 1'b1; p_we = 1'b1; p_addr = 12'h0AB; p_wdata = 32'h55AA55AA;
    g_req = 1'b1; g_we = 1'b1; g_addr = 12'h0CD; g_wdata = 32'h11223344;
    next_cycle(); #1;
    chk("rst_wren", wren, 1'b0);
    chk("rst_g_gnt", g_gnt, 1'b0);
    chk("rst_p_stall", p_stall, 1'b0);
    chk("rst_g_rvalid", g_rvalid, 1'b0);
    chk("rst_addr", address_dmem, 12'h000);
    chk("rst_data", data, 32'h0);
    chk("rst_wait_cnt", dut.wait_cnt_q, 4'd0);

    next_cycle();
    reset = 1'b1;
    p_req = 1'b0; p_we = 1'b0; g_req = 1'b0; g_we = 1'b0;

    // G-only read of 0x010.
    next_cycle();
    g_req = 1'b1; g_we = 1'b0; g_addr = 12'h010;
    #1;
    chk("g_only_gnt", g_gnt, 1'b1);
    chk("g_only_addr", address_dmem, 12'h010);
    chk("g_only_wren", wren, 1'b0);
    chk("g_only_p_stall", p_stall, 1'b0);
    next_cycle();
    g_req = 1'b0;
    #1;
    chk("g_only_rvalid", g_rvalid, 1'b1);
    chk("g_only_rdata", g_rdata, 32'hCAFEF00D);
    next_cycle(); #1;
    chk("g_only_rvalid_pulse", g_rvalid, 1'b0);

    // Contention: P wins cycles 0..6, G forced in cycle 7, P again in cycle 8.
    next_cycle();
    p_req = 1'b1; p_we = 1'b0; p_addr = 12'h100;
    g_req = 1'b1; g_we = 1'b0; g_addr = 12'h200;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) next_cycle();
      #1;
      chk($sformatf("cont_g_gnt_c%0d", c), g_gnt, (c == 7) ? 1'b1 : 1'b0);
      chk($sformatf("cont_p_stall_c%0d", c), p_stall, (c == 7) ? 1'b1 : 1'b0);
      chk($sformatf("cont_g_rvalid_c%0d", c), g_rvalid, (c == 8) ? 1'b1 : 1'b0);
      if (c == 7) chk("cont_force_addr", address_dmem, 12'h200);
      if (c == 8) begin
        chk("cont_c8_wait_cnt", dut.wait_cnt_q, 4'd0);
        chk("cont_c8_g_rdata", g_rdata, 32'h12345678);
        chk("cont_c8_addr", address_dmem, 12'h100);
      end
    end
    next_cycle();
    p_req = 1'b0; g_req = 1'b0;

    // P writes 0x42 to 0x020, then G reads it back.
    next_cycle();
    p_req = 1'b1; p_we = 1'b1; p_addr = 12'h020; p_wdata = 32'h00000042;
    #1;
    chk("pw_wren", wren, 1'b1);
    chk("pw_addr", address_dmem, 12'h020);
    chk("pw_data", data, 32'h00000042);
    chk("pw_p_stall", p_stall, 1'b0);
    next_cycle();
    p_req = 1'b0; p_we = 1'b0;
    g_req = 1'b1; g_we = 1'b0; g_addr = 12'h020;
    #1;
    chk("gr_gnt", g_gnt, 1'b1);
    chk("gr_wren", wren, 1'b0);
    next_cycle();
    g_req = 1'b0;
    #1;
    chk("gr_rvalid", g_rvalid, 1'b1);
    chk("gr_rdata", g_rdata, 32'h00000042);
    chk("idle_wren", wren, 1'b0);
    chk("idle_addr_hold", address_dmem, 12'h020);

    // Back-to-back G reads of 0x001 and 0x002.
    next_cycle();
    g_req = 1'b1; g_we = 1'b0; g_addr = 12'h001;
    #1;
    chk("b2b_gnt0", g_gnt, 1'b1);
    next_cycle();
    g_addr = 12'h002;
    #1;
    chk("b2b_gnt1", g_gnt, 1'b1);
    chk("b2b_rvalid0", g_rvalid, 1'b1);
    chk("b2b_rdata0", g_rdata, 32'hA0A00001);
    next_cycle();
    g_req = 1'b0;
    #1;
    chk("b2b_rvalid1", g_rvalid, 1'b1);
    chk("b2b_rdata1", g_rdata, 32'hB0B00002);
    next_cycle(); #1;
    chk("b2b_rvalid_end", g_rvalid, 1'b0);

    // Reset one cycle after a G read grant discards the pending return.
    next_cycle();
    g_req = 1'b1; g_we = 1'b0; g_addr = 12'h010;
    #1;
    chk("rmr_gnt", g_gnt, 1'b1);
    next_cycle();
    g_req = 1'b0;
    reset = 1'b0;
    p_req = 1'b1; p_we = 1'b1; p_addr = 12'h077; p_wdata = 32'hFFFF0000;
    #1;
    chk("rmr_rvalid", g_rvalid, 1'b0);
    chk("rmr_wren", wren, 1'b0);
    chk("rmr_addr", address_dmem, 12'h000);
    chk("rmr_data", data, 32'h0);
    chk("rmr_p_stall", p_stall, 1'b0);
    chk("rmr_g_rdata", g_rdata, 32'h0);
    next_cycle(); #1;
    chk("rmr_rvalid_later", g_rvalid, 1'b0);
    next_cycle();
    reset = 1'b1;
    p_we = 1'b0; p_addr = 12'h030;
    #1;
    chk("rmr_p_first_stall", p_stall, 1'b0);
    chk("rmr_p_first_addr", address_dmem, 12'h030);
    next_cycle(); #1;
    chk("rmr_p_no_g_rvalid", g_rvalid, 1'b0);

    // G abort after three lost cycles.
    p_req = 1'b1; p_we = 1'b0; p_addr = 12'h031;
    g_req = 1'b1; g_we = 1'b1; g_addr = 12'h040; g_wdata = 32'h0000DEAD;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) next_cycle();
      #1;
      chk($sformatf("abort_g_gnt_c%0d", c), g_gnt, 1'b0);
      chk($sformatf("abort_wren_c%0d", c), wren, 1'b0);
    end
    next_cycle();
    #1;
    chk("abort_wait_cnt3", dut.wait_cnt_q, 4'd3);
    p_req = 1'b0; g_req = 1'b0;
    #1;
    chk("abort_drop_gnt", g_gnt, 1'b0);
    chk("abort_drop_wren", wren, 1'b0);
    next_cycle(); #1;
    chk("abort_wait_cnt0", dut.wait_cnt_q, 4'd0);
    chk("abort_wren_idle", wren, 1'b0);
    chk("abort_mem_untouched", mem[12'h040], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
